// File: rtl/cdr_loop_nco_if.sv
// Bundle between the CDR phase detector and the loop filter / NCO.
// The detector side (master) drives the phase error strobe and the freeze
// control; the NCO side (slave) returns the regenerated clock and status.
interface cdr_loop_nco_if;
    logic signed [3:0] phase_error;
    logic              pe_valid;
    logic              freeze;
    logic              recovered_clk;
    logic [5:0]        period;
    logic              locked;
    logic              int_sat;

    modport master (
        output phase_error,
        output pe_valid,
        output freeze,
        input  recovered_clk,
        input  period,
        input  locked,
        input  int_sat
    );

    modport slave (
        input  phase_error,
        input  pe_valid,
        input  freeze,
        output recovered_clk,
        output period,
        output locked,
        output int_sat
    );
endinterface

// File: rtl/cdr_loop_nco.sv
// PI loop filter and clock-divider NCO closing the CDR loop.
// The phase error is integrated with saturation, combined with a proportional
// term into a period correction, and the divider picks up the corrected
// period only at a wrap so no period is ever truncated or stretched.
module cdr_loop_nco #(
    parameter int NOM_PERIOD = 16,
    parameter int MIN_PERIOD = 8,
    parameter int MAX_PERIOD = 32,
    parameter int KP         = 1,
    parameter int KI_SHIFT   = 2,
    parameter int INT_W      = 10,
    parameter int LOCK_TOL   = 1,
    parameter int LOCK_COUNT = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    cdr_loop_nco_if.slave  nco
);

    localparam int LCW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [15:0]      KP_S    = 16'(KP);
    localparam logic signed [15:0]      NOM_S   = 16'(NOM_PERIOD);
    localparam logic signed [15:0]      MIN_S   = 16'(MIN_PERIOD);
    localparam logic signed [15:0]      MAX_S   = 16'(MAX_PERIOD);
    localparam logic [5:0]              NOM_P   = 6'(NOM_PERIOD);
    localparam logic [5:0]              MIN_P   = 6'(MIN_PERIOD);
    localparam logic [5:0]              MAX_P   = 6'(MAX_PERIOD);
    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [LCW-1:0]          LOCK_N  = LCW'(LOCK_COUNT);

    logic [5:0]              cnt;
    logic [5:0]              period_q;
    logic [5:0]              next_period;
    logic signed [INT_W-1:0] integ;
    logic signed [3:0]       pe_reg;
    logic [LCW-1:0]          lock_cnt;
    logic                    rclk_q;
    logic                    locked_q;
    logic                    int_sat_q;

    // Integrator sum one bit wider so overflow shows up as a sign mismatch.
    logic signed [INT_W:0]   sum_ext;
    logic                    sum_ovf;
    logic signed [INT_W-1:0] sum_sat;

    logic signed [15:0]      pe16;
    logic signed [15:0]      integ16;
    logic signed [15:0]      corr;
    logic signed [15:0]      target;
    logic [5:0]              target_clamped;

    logic signed [4:0]       pe5;
    logic [4:0]              pe_abs;
    logic                    in_tol;
    logic [LCW-1:0]          lock_cnt_nxt;

    // Saturating integrator input and PI correction from registered state.
    always_comb begin
        sum_ext = {integ[INT_W-1], integ} + {{(INT_W-3){nco.phase_error[3]}}, nco.phase_error};
        sum_ovf = (sum_ext[INT_W] != sum_ext[INT_W-1]);
        sum_sat = sum_ovf ? (sum_ext[INT_W] ? INT_MIN : INT_MAX) : sum_ext[INT_W-1:0];

        pe16    = {{12{pe_reg[3]}}, pe_reg};
        integ16 = {{(16-INT_W){integ[INT_W-1]}}, integ};
        corr    = KP_S * pe16 + (integ16 >>> KI_SHIFT);
        target  = NOM_S - corr;

        if (target < MIN_S)
            target_clamped = MIN_P;
        else if (target > MAX_S)
            target_clamped = MAX_P;
        else
            target_clamped = target[5:0];
    end

    // Lock qualifier; |-8| must come out as 8, hence the 5-bit magnitude.
    always_comb begin
        pe5    = {nco.phase_error[3], nco.phase_error};
        pe_abs = pe5[4] ? 5'(-pe5) : pe5;
        in_tol = (pe_abs <= 5'(LOCK_TOL));
        lock_cnt_nxt = lock_cnt;
        if (nco.pe_valid) begin
            if (!in_tol)
                lock_cnt_nxt = '0;
            else if (lock_cnt != LOCK_N)
                lock_cnt_nxt = lock_cnt + 1'b1;
        end
    end

    // Filter state advances on each accepted strobe unless frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_reg    <= '0;
            integ     <= '0;
            int_sat_q <= 1'b0;
        end else if (nco.pe_valid && !nco.freeze) begin
            pe_reg    <= nco.phase_error;
            integ     <= sum_sat;
            int_sat_q <= sum_ovf;
        end
    end

    // Period target registered every cycle from the filter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            next_period <= NOM_P;
        else
            next_period <= target_clamped;
    end

    // Divider: new period is only picked up at the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            period_q <= NOM_P;
        end else if (cnt == period_q - 6'd1) begin
            cnt      <= '0;
            period_q <= next_period;
        end else begin
            cnt      <= cnt + 6'd1;
        end
    end

    // Registered clock: high for the first floor(P/2) counts of each period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rclk_q <= 1'b0;
        else
            rclk_q <= (cnt < (period_q >> 1));
    end

    // Lock counter and flag; flag follows the counter's next value so it
    // moves one cycle after the deciding strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= '0;
            locked_q <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
            locked_q <= (lock_cnt_nxt == LOCK_N);
        end
    end

    assign nco.recovered_clk = rclk_q;
    assign nco.period        = period_q;
    assign nco.locked        = locked_q;
    assign nco.int_sat       = int_sat_q;

endmodule

// File: tb/tb_cdr_loop_nco.sv
// Directed plus randomized bench for cdr_loop_nco against a behavioural
// model of the loop (integer arithmetic on the filter and an ideal divider).
module tb_cdr_loop_nco;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    cdr_loop_nco_if bus ();

    cdr_loop_nco dut (
        .clk     (clk),
        .reset_n (reset_n),
        .nco     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_pos, m_period, m_np, m_integ, m_pe, m_lock;
    int m_rclk, m_locked, m_sat;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_period = 16; m_np = 16; m_integ = 0; m_pe = 0;
        m_lock = 0; m_rclk = 0; m_locked = 0; m_sat = 0;
    endtask

    function automatic int floor_div4(input int v);
        if (v >= 0) return v / 4;
        return -((-v + 3) / 4);
    endfunction

    task automatic model_edge(input bit pv, input int pe, input bit frz);
        int corr, tgt, sum, mag;
        corr = 1 * m_pe + floor_div4(m_integ);
        tgt  = 16 - corr;
        if (tgt < 8)  tgt = 8;
        if (tgt > 32) tgt = 32;
        m_rclk = (m_pos < m_period / 2) ? 1 : 0;
        if (m_pos == m_period - 1) begin
            m_pos = 0;
            m_period = m_np;
        end else begin
            m_pos++;
        end
        m_np = tgt;
        if (pv && !frz) begin
            sum   = m_integ + pe;
            m_sat = (sum > 511 || sum < -512) ? 1 : 0;
            if (sum > 511)  sum = 511;
            if (sum < -512) sum = -512;
            m_integ = sum;
            m_pe    = pe;
        end
        if (pv) begin
            mag = (pe < 0) ? -pe : pe;
            if (mag <= 1) m_lock = (m_lock < 8) ? m_lock + 1 : 8;
            else          m_lock = 0;
        end
        m_locked = (m_lock == 8) ? 1 : 0;
    endtask

    task automatic step(input bit pv, input int pe, input bit frz);
        bus.pe_valid    = pv;
        bus.phase_error = 4'(pe);
        bus.freeze      = frz;
        @(posedge clk);
        model_edge(pv, pe, frz);
        #1;
        check("rclk",    16'(bus.recovered_clk), 16'(m_rclk));
        check("period",  16'(bus.period),        16'(m_period));
        check("locked",  16'(bus.locked),        16'(m_locked));
        check("int_sat", 16'(bus.int_sat),       16'(m_sat));
        bus.pe_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rclk"},    16'(bus.recovered_clk), 16'd0);
        check({tag, "_period"},  16'(bus.period),        16'd16);
        check({tag, "_locked"},  16'(bus.locked),        16'd0);
        check({tag, "_int_sat"}, 16'(bus.int_sat),       16'd0);
    endtask

    initial begin
        int found;
        int lock_seq [8] = '{0, 1, -1, 0, 0, 1, -1, 0};
        int hi_run, lo_run;
        n_vec = 0;
        n_err = 0;
        reset_n         = 1'b0;
        bus.pe_valid    = 1'b0;
        bus.phase_error = 4'sd0;
        bus.freeze      = 1'b0;
        model_reset();

        #12;
        check_reset_outputs("in_reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Idle: nominal 8 high / 8 low
        for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b0);

        // Single +4 strobe: period goes to 11 (5 high / 6 low)
        step(1'b1, 4, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b0);
        check("p11", 16'(bus.period), 16'd11);
        hi_run = 0; lo_run = 0;
        while (!(m_pos == 0 && m_period == 11) && hi_run < 40) begin
            step(1'b0, 0, 1'b0);
            hi_run++;
        end
        hi_run = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 0, 1'b0);
            if (bus.recovered_clk) hi_run++; else lo_run++;
        end
        check("p11_high", 16'(hi_run), 16'd5);
        check("p11_low",  16'(lo_run), 16'd6);

        // Reset mid-period at cnt=5 while period=11
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            step(1'b0, 0, 1'b0);
            if (m_pos == 5 && m_period == 11) found = 1;
        end
        check("midrst_reach", 16'(found), 16'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 34; i++) step(1'b0, 0, 1'b0);

        // Freeze with five +7 strobes: nothing moves, no lock
        for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b0);
        check("frz_period", 16'(bus.period), 16'd16);
        check("frz_locked", 16'(bus.locked), 16'd0);

        // Sustained -8: integrator saturates, period clamps at 32
        for (int i = 0; i < 200; i++) step(1'b1, -8, 1'b0);
        check("sat_flag", 16'(bus.int_sat), 16'd1);
        for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b0);
        check("clamp32", 16'(bus.period), 16'd32);
        step(1'b1, 1, 1'b0);
        check("sat_clear", 16'(bus.int_sat), 16'd0);

        // Lock sequence then an out-of-tolerance strobe
        for (int i = 0; i < 8; i++) begin
            step(1'b1, lock_seq[i], 1'b0);
            if (i < 7) step(1'b0, 0, 1'b0);
        end
        check("lock_hi", 16'(bus.locked), 16'd1);
        step(1'b0, 0, 1'b0);
        step(1'b1, 3, 1'b0);
        check("lock_lo", 16'(bus.locked), 16'd0);

        // Randomized traffic, including lock-friendly stretches
        for (int i = 0; i < 300; i++) begin
            bit pv, frz;
            int pe;
            pv  = ($urandom_range(3) == 0);
            frz = ($urandom_range(7) == 0);
            if ((i / 60) % 2 == 1) pe = int'($urandom_range(2)) - 1;
            else                   pe = int'($urandom_range(15)) - 8;
            step(pv, pe, frz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
